// File: rtl/demux_1x32_deser_if.sv
// Bus bundle for the serial-to-parallel deserializer.
// Ports (seen from the deserializer, slave modport):
//   din, din_valid   in   serial bit and its qualifier
//   din_ready        out  deserializer can take din this cycle
//   flush            in   abort the partial frame
//   dout             out  assembled WIDTH-bit frame
//   dout_valid       out  dout holds an unconsumed frame
//   dout_ready       in   consumer takes dout this cycle
//   bit_idx          out  count of bits accepted in the current frame
interface demux_1x32_deser_if #(
   parameter int unsigned WIDTH = 32
);
   logic             din;
   logic             din_valid;
   logic             din_ready;
   logic             flush;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic [4:0]       bit_idx;

   modport master (
      output din, din_valid, flush, dout_ready,
      input  din_ready, dout, dout_valid, bit_idx
   );

   modport slave (
      input  din, din_valid, flush, dout_ready,
      output din_ready, dout, dout_valid, bit_idx
   );
endinterface

// File: rtl/demux_1x32_deser.sv
// Serial-to-parallel deserializer. Each accepted serial bit lands in slot bit_idx
// (or WIDTH-1-bit_idx when MSB_FIRST) of a frame buffer; completed frames move to a
// valid/ready output register. The frame buffer doubles as a second output stage:
// if a frame completes while the output is still occupied, the block stalls the
// serial side until the consumer takes the held word.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  synchronous reset, active low
//   bus    slave modport of demux_1x32_deser_if (serial in, parallel out, flush, bit_idx)
module demux_1x32_deser #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          MSB_FIRST = 1'b0
) (
   input logic                clk,
   input logic                rst_n,
   demux_1x32_deser_if.slave  bus
);

   localparam int unsigned IdxW    = $clog2(WIDTH);
   localparam logic [4:0]  LastIdx = 5'(WIDTH - 1);

   typedef enum logic [0:0] {StFill, StStall} state_e;

   state_e           state_q, state_d;
   logic [4:0]       bit_idx_q, bit_idx_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;

   logic             din_ready;
   logic             accept;
   logic             take;
   logic [IdxW-1:0]  slot;

   // Ready is purely a function of registered state: no path from dout_ready.
   assign din_ready = (state_q == StFill);
   assign accept    = bus.din_valid & din_ready;
   assign take      = dout_valid_q & bus.dout_ready;
   assign slot      = MSB_FIRST ? (IdxW'(WIDTH - 1) - bit_idx_q[IdxW-1:0])
                                : bit_idx_q[IdxW-1:0];

   always_comb begin
      state_d      = state_q;
      bit_idx_d    = bit_idx_q;
      buf_d        = buf_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;

      // A take empties the output unless a frame is loaded below in the same cycle.
      if (take) begin
         dout_valid_d = 1'b0;
      end

      if (bus.flush) begin
         // Drops the partial frame and, in StStall, the frame parked in the buffer.
         bit_idx_d = '0;
         state_d   = StFill;
      end else begin
         unique case (state_q)
            StFill: begin
               if (accept) begin
                  buf_d[slot] = bus.din;
                  if (bit_idx_q == LastIdx) begin
                     bit_idx_d = '0;
                     if (!dout_valid_q || take) begin
                        dout_d       = buf_d;
                        dout_valid_d = 1'b1;
                     end else begin
                        state_d = StStall;
                     end
                  end else begin
                     bit_idx_d = bit_idx_q + 5'd1;
                  end
               end
            end
            StStall: begin
               if (take) begin
                  dout_d       = buf_q;
                  dout_valid_d = 1'b1;
                  state_d      = StFill;
               end
            end
            default: state_d = StFill;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StFill;
         bit_idx_q    <= '0;
         buf_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_idx_q    <= bit_idx_d;
         buf_q        <= buf_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign bus.din_ready  = din_ready;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.bit_idx    = bit_idx_q;

endmodule

// File: tb/tb_demux_1x32_deser.sv
module tb_demux_1x32_deser;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux_1x32_deser_if #(.WIDTH(W)) bus ();
   demux_1x32_deser_if #(.WIDTH(W)) bus_m ();

   demux_1x32_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );
   demux_1x32_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst_n(rst_n), .bus(bus_m.slave)
   );

   int total = 0;
   int bad = 0;

   // Reference model: frames completed but not yet taken, in order; front is on dout.
   logic [W-1:0] m_q[$];
   logic [W-1:0] m_acc;
   logic [W-1:0] m_last;
   int           m_cnt;

   function automatic logic [W-1:0] exp_dout();
      return (m_q.size() > 0) ? m_q[0] : m_last;
   endfunction

   // Drive one cycle on the LSB-first DUT and advance the model across the edge.
   task automatic step(input logic d, input logic v, input logic f, input logic r);
      logic ready;
      logic accept;
      bus.din = d; bus.din_valid = v; bus.flush = f; bus.dout_ready = r;
      if (!rst_n) begin
         m_q.delete(); m_acc = '0; m_last = '0; m_cnt = 0;
      end else begin
         ready  = (m_q.size() < 2);
         accept = v && ready && !f;
         if (f) begin
            m_cnt = 0; m_acc = '0;
            if (m_q.size() == 2) m_q.delete(1);
         end
         if (m_q.size() > 0 && r) m_last = m_q.pop_front();
         if (accept) begin
            m_acc = m_acc | (W'(d) << m_cnt);
            m_cnt++;
            if (m_cnt == W) begin
               m_q.push_back(m_acc); m_acc = '0; m_cnt = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.dout !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", bus.dout); end
      total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.dout_valid); end
      total++; if (bus.bit_idx !== 5'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", bus.bit_idx); end
      total++; if (bus.din_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.din_ready); end
   endtask

   task automatic test_lsb_stream();
      logic [W-1:0] word;
      word = 32'hA5C3_0F81;
      do_reset();
      for (int k = 0; k < W; k++) begin
         total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid bit=%0d got=%b want=0", k, bus.dout_valid); end
         step(word[k], 1'b1, 1'b0, 1'b1);
      end
      total++; if (bus.dout !== 32'hA5C3_0F81) begin bad++; $display("FAIL stream_dout got=%h want=a5c30f81", bus.dout); end
      total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL stream_valid got=%b want=1", bus.dout_valid); end
      total++; if (bus.bit_idx !== 5'd0) begin bad++; $display("FAIL stream_idx_wrap got=%0d want=0", bus.bit_idx); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL stream_valid_drop got=%b want=0", bus.dout_valid); end
      total++; if (bus.dout !== 32'hA5C3_0F81) begin bad++; $display("FAIL stream_dout_hold got=%h want=a5c30f81", bus.dout); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] w0, w1;
      w0 = 32'h1234_5678; w1 = 32'hDEAD_BEEF;
      do_reset();
      for (int k = 0; k < W; k++) step(w0[k], 1'b1, 1'b0, 1'b0);
      total++; if (bus.dout !== w0 || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%b want=12345678/1", bus.dout, bus.dout_valid); end
      total++; if (bus.din_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_mid got=%b want=1", bus.din_ready); end
      for (int k = 0; k < W; k++) step(w1[k], 1'b1, 1'b0, 1'b0);
      total++; if (bus.din_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready got=%b want=0", bus.din_ready); end
      // Bits offered during the stall must not be consumed.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      total++; if (bus.dout !== w0 || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL b2b_hold got=%h/%b want=12345678/1", bus.dout, bus.dout_valid); end
      total++; if (bus.bit_idx !== 5'd0) begin bad++; $display("FAIL b2b_ignored_idx got=%0d want=0", bus.bit_idx); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (bus.dout !== w1 || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%b want=deadbeef/1", bus.dout, bus.dout_valid); end
      total++; if (bus.din_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_back got=%b want=1", bus.din_ready); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", bus.dout_valid); end
   endtask

   task automatic test_flush();
      logic [W-1:0] word;
      word = 32'hFFFF_0000;
      do_reset();
      for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, 1'b1);
      total++; if (bus.bit_idx !== 5'd10) begin bad++; $display("FAIL flush_pre_idx got=%0d want=10", bus.bit_idx); end
      step(1'b1, 1'b1, 1'b1, 1'b1);
      total++; if (bus.bit_idx !== 5'd0) begin bad++; $display("FAIL flush_idx got=%0d want=0", bus.bit_idx); end
      for (int k = 0; k < W; k++) step(word[k], 1'b1, 1'b0, 1'b1);
      total++; if (bus.dout !== 32'hFFFF_0000 || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL flush_dout got=%h/%b want=ffff0000/1", bus.dout, bus.dout_valid); end
      // Flush during stall discards the parked frame but not the held output.
      for (int k = 0; k < 2 * W; k++) step(k[0], 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      total++; if (bus.din_ready !== 1'b1 || bus.dout !== 32'hFFFF_0000) begin bad++; $display("FAIL flush_stall got=%b/%h want=1/ffff0000", bus.din_ready, bus.dout); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL flush_stall_drop got=%b want=0", bus.dout_valid); end
   endtask

   task automatic test_msb_first();
      logic [W-1:0] word, want;
      do_reset();
      bus_m.din_valid = 1'b1;
      for (int k = 0; k < W; k++) begin
         bus_m.din = (k == 0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      bus_m.din_valid = 1'b0;
      total++; if (bus_m.dout !== 32'h8000_0000 || bus_m.dout_valid !== 1'b1) begin bad++; $display("FAIL msb_single got=%h/%b want=80000000/1", bus_m.dout, bus_m.dout_valid); end
      word = $urandom;
      want = '0;
      bus_m.din_valid = 1'b1;
      for (int k = 0; k < W; k++) begin
         bus_m.din = word[k];
         want = want | (W'(word[k]) << (W - 1 - k));
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      bus_m.din_valid = 1'b0;
      total++; if (bus_m.dout !== want || bus_m.dout_valid !== 1'b1) begin bad++; $display("FAIL msb_random got=%h/%b want=%h/1", bus_m.dout, bus_m.dout_valid, want); end
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random_gaps();
      logic d, v, f, r;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         d = 1'($urandom);
         v = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 59) == 0);
         r = ($urandom_range(0, 2) == 0);
         step(d, v, f, r);
         total++;
         if (bus.bit_idx !== 5'(m_cnt) || bus.dout_valid !== (m_q.size() > 0) ||
             bus.din_ready !== (m_q.size() < 2) || bus.dout !== exp_dout()) begin
            bad++;
            $display("FAIL rand_cycle c=%0d got idx=%0d v=%b rdy=%b dout=%h want idx=%0d v=%b rdy=%b dout=%h",
                     c, bus.bit_idx, bus.dout_valid, bus.din_ready, bus.dout,
                     m_cnt, (m_q.size() > 0), (m_q.size() < 2), exp_dout());
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int guard;
      do_reset();
      for (int k = 0; k < W; k++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
      guard = 0;
      while (m_cnt != 20 && guard < 200) begin
         step(1'($urandom), ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
         guard++;
      end
      total++; if (bus.bit_idx !== 5'd20 || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%0d/%b want=20/1", bus.bit_idx, bus.dout_valid); end
      rst_n = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      total++; if (bus.bit_idx !== 5'd0 || bus.dout_valid !== 1'b0 || bus.dout !== 32'h0) begin bad++; $display("FAIL midrst got=%0d/%b/%h want=0/0/0", bus.bit_idx, bus.dout_valid, bus.dout); end
   endtask

   initial begin
      bus.din = 1'b0; bus.din_valid = 1'b0; bus.flush = 1'b0; bus.dout_ready = 1'b0;
      bus_m.din = 1'b0; bus_m.din_valid = 1'b0; bus_m.flush = 1'b0; bus_m.dout_ready = 1'b1;
      m_acc = '0; m_last = '0; m_cnt = 0;
      #1;
      test_reset();
      test_lsb_stream();
      test_back_to_back();
      test_flush();
      test_msb_first();
      test_random_gaps();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
